// File: rtl/data_sram_slave.sv
// data_sram_slave
//   SRAM-like responder for the execute-stage data port. Requests accepted on
//   the req/addrok handshake are queued in a small in-order FIFO. Each one is
//   replayed onto a synchronous single-port SRAM that has a 1-cycle read
//   latency. Every request, read or write, gets exactly one dataok pulse.
//
// Parameters
//   DEPTH       request FIFO entries (power of two, >= 2)
//   RESP_DELAY  extra wait cycles before each SRAM issue (0..255)
//   ADDR_WIDTH  SRAM word-index width (<= 29)
//
// Ports
//   clk, resetn        clock; asynchronous active-low reset
//   data_sram_req      request valid
//   data_sram_wr       1 = write, 0 = read
//   data_sram_size     access size (queued and carried only)
//   data_sram_addr     byte address
//   data_sram_wstrb    write byte enables
//   data_sram_wdata    lane-aligned write data
//   data_sram_addrok   slave can accept (FIFO not full)
//   data_sram_dataok   one-cycle response pulse
//   data_sram_rdata    SRAM word for reads during dataok, else 0
//   ram_en/ram_wen/ram_addr/ram_wdata   SRAM access, driven only in ISSUE
//   ram_rdata          SRAM read data, valid the cycle after ram_en
module data_sram_slave #(
  parameter int DEPTH      = 2,
  parameter int RESP_DELAY = 0,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  data_sram_req,
  input  logic                  data_sram_wr,
  input  logic [1:0]            data_sram_size,
  input  logic [31:0]           data_sram_addr,
  input  logic [3:0]            data_sram_wstrb,
  input  logic [31:0]           data_sram_wdata,
  output logic                  data_sram_addrok,
  output logic                  data_sram_dataok,
  output logic [31:0]           data_sram_rdata,
  output logic                  ram_en,
  output logic [3:0]            ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [7:0]      DELAY   = 8'(RESP_DELAY);
  localparam logic [PTR_W:0]  PTR_ONE = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;

  // Request storage; no reset needed since the pointers define validity.
  logic                  fifo_wr    [DEPTH];
  logic [1:0]            fifo_size  [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [DEPTH];
  logic [3:0]            fifo_wstrb [DEPTH];
  logic [31:0]           fifo_wdata [DEPTH];

  logic                  empty, full, push, pop;
  logic [PTR_W-1:0]      wr_idx, rd_idx;
  logic                  head_wr;
  logic [1:0]            head_size;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [3:0]            head_wstrb;
  logic [31:0]           head_wdata;

  assign wr_idx = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx = rd_ptr_reg[PTR_W-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);

  // addrok depends on registered pointers only, never on req, so the master
  // cannot form a combinational loop through it.
  assign data_sram_addrok = !full;
  assign push             = data_sram_req && !full;
  assign pop              = (state_reg == RESP);

  assign head_wr    = fifo_wr[rd_idx];
  assign head_size  = fifo_size[rd_idx];
  assign head_addr  = fifo_addr[rd_idx];
  assign head_wstrb = fifo_wstrb[rd_idx];
  assign head_wdata = fifo_wdata[rd_idx];

  // Size and the byte-offset/high address bits are carried but never steer
  // the SRAM word access; lane selection is the job of wstrb or the master.
  logic unused_bits;
  assign unused_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0], head_size};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_idx]    <= data_sram_wr;
      fifo_size[wr_idx]  <= data_sram_size;
      fifo_addr[wr_idx]  <= data_sram_addr[ADDR_WIDTH+1:2];
      fifo_wstrb[wr_idx] <= data_sram_wstrb;
      fifo_wdata[wr_idx] <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      state_reg  <= IDLE;
      cnt_reg    <= 8'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    ram_en           = 1'b0;
    ram_wen          = 4'b0000;
    ram_addr         = '0;
    ram_wdata        = 32'd0;
    data_sram_dataok = 1'b0;
    data_sram_rdata  = 32'd0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          cnt_next   = DELAY;
          state_next = (DELAY != 8'd0) ? WAIT : ISSUE;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) state_next = ISSUE;
      end
      ISSUE: begin
        ram_en     = 1'b1;
        ram_wen    = head_wr ? head_wstrb : 4'b0000;
        ram_addr   = head_addr;
        ram_wdata  = head_wdata;
        state_next = RESP;
      end
      RESP: begin
        // The head is still in the FIFO here; it is popped on this edge.
        data_sram_dataok = 1'b1;
        data_sram_rdata  = head_wr ? 32'd0 : ram_rdata;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: two instances (RESP_DELAY 0 and 4, DEPTH 2),
// each with a small SRAM model. A transaction-level model predicts response
// timing, SRAM issue contents, addrok and read data; a monitor compares the
// DUTs every cycle, and directed steps pin a few hand-computed values.
module tb_data_sram_slave;

  localparam int DEPTH = 2;

  logic        clk;
  logic        resetn;
  logic        req       [2];
  logic        wr        [2];
  logic [1:0]  size      [2];
  logic [31:0] addr      [2];
  logic [3:0]  wstrb     [2];
  logic [31:0] wdata     [2];
  logic        addrok    [2];
  logic        dataok    [2];
  logic [31:0] rdata     [2];
  logic        ram_en    [2];
  logic [3:0]  ram_wen   [2];
  logic [15:0] ram_addr  [2];
  logic [31:0] ram_wdata [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [31:0] rd_q;
    logic [31:0] mem [256];

    data_sram_slave #(.DEPTH(DEPTH), .RESP_DELAY(gi * 4), .ADDR_WIDTH(16)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .data_sram_req    (req[gi]),
      .data_sram_wr     (wr[gi]),
      .data_sram_size   (size[gi]),
      .data_sram_addr   (addr[gi]),
      .data_sram_wstrb  (wstrb[gi]),
      .data_sram_wdata  (wdata[gi]),
      .data_sram_addrok (addrok[gi]),
      .data_sram_dataok (dataok[gi]),
      .data_sram_rdata  (rdata[gi]),
      .ram_en           (ram_en[gi]),
      .ram_wen          (ram_wen[gi]),
      .ram_addr         (ram_addr[gi]),
      .ram_wdata        (ram_wdata[gi]),
      .ram_rdata        (rd_q)
    );

    always @(posedge clk) begin
      if (ram_en[gi]) begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[gi][b]) mem[ram_addr[gi][7:0]][8*b +: 8] <= ram_wdata[gi][8*b +: 8];
        rd_q <= mem[ram_addr[gi][7:0]];
      end
    end
  end

  // ---------------- transaction-level model ----------------
  typedef struct {
    int          acc;    // edge at which the request is accepted
    int          resp;   // edge after which dataok is high
    logic        wr;
    logic [15:0] word;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } ent_t;

  ent_t        mq        [2][64];
  int          mh        [2];
  int          mt        [2];
  int          last_resp [2];
  logic [31:0] ref_mem   [2][256];
  int          resp_count[2];
  int          resp_cyc  [2][64];

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d actual=%0h required=%0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    int   occ, start;
    ent_t h, e;
    logic x_ok, x_dok, x_en;
    logic [31:0] x_rd, x_wd;
    logic [3:0]  x_wen;
    logic [15:0] x_addr;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!resetn) begin
          mh[i] = mt[i];
          last_resp[i] = -100;
        end
        // an entry leaves the queue on the edge after its response cycle
        while (mh[i] != mt[i] && mq[i][mh[i] % 64].resp + 1 <= cyc) mh[i]++;
        occ = 0;
        for (int k = mh[i]; k < mt[i]; k++) if (mq[i][k % 64].acc <= cyc) occ++;
        x_ok = (occ < DEPTH);
        x_dok = 1'b0; x_rd = 32'd0; x_en = 1'b0; x_wen = 4'd0; x_addr = 16'd0; x_wd = 32'd0;
        if (mh[i] != mt[i]) begin
          h = mq[i][mh[i] % 64];
          if (cyc == h.resp) begin
            x_dok = 1'b1;
            x_rd  = h.wr ? 32'd0 : h.rdata;
          end
          if (cyc == h.resp - 1) begin
            x_en   = 1'b1;
            x_wen  = h.wr ? h.wen : 4'd0;
            x_addr = h.word;
            x_wd   = h.wdata;
          end
        end
        check("addrok", i, 32'(addrok[i]), 32'(x_ok));
        check("dataok", i, 32'(dataok[i]), 32'(x_dok));
        check("rdata", i, rdata[i], x_rd);
        check("ram_en", i, 32'(ram_en[i]), 32'(x_en));
        check("ram_wen", i, 32'(ram_wen[i]), 32'(x_wen));
        check("ram_addr", i, 32'(ram_addr[i]), 32'(x_addr));
        check("ram_wdata", i, ram_wdata[i], x_wd);
        if (dataok[i]) begin
          resp_cyc[i][resp_count[i] % 64] = cyc;
          resp_count[i]++;
          $display("inst%0d cyc%0d dataok rdata=%08h", i, cyc, rdata[i]);
        end
        // request presented now is sampled on the coming edge
        if (resetn && req[i] && x_ok) begin
          e.acc   = cyc + 1;
          start   = (e.acc > last_resp[i] + 1) ? e.acc : last_resp[i] + 1;
          e.resp  = start + 2 + i * 4;
          last_resp[i] = e.resp;
          e.wr    = wr[i];
          e.word  = addr[i][17:2];
          e.wen   = wstrb[i];
          e.wdata = wdata[i];
          e.rdata = ref_mem[i][addr[i][9:2]];
          if (wr[i])
            for (int b = 0; b < 4; b++)
              if (wstrb[i][b]) ref_mem[i][addr[i][9:2]][8*b +: 8] = wdata[i][8*b +: 8];
          mq[i][mt[i] % 64] = e;
          mt[i]++;
          $display("inst%0d cyc%0d accept wr=%0d addr=%08h wstrb=%h wdata=%08h", i, cyc + 1,
                   wr[i], addr[i], wstrb[i], wdata[i]);
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Holds the request until it is accepted; returns the acceptance edge.
  task automatic send(input int i, input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [3:0] st, input logic [31:0] d, output int acc_edge);
    bit ok, was;
    req[i] = 1'b1; wr[i] = w; size[i] = sz; addr[i] = a; wstrb[i] = st; wdata[i] = d;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      was = addrok[i];
      @(posedge clk);
      #2;
      if (was) begin
        ok = 1'b1;
        break;
      end
    end
    acc_edge = cyc;
    if (!ok) check("send_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic idle(input int i);
    req[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i, input int target);
    for (int n = 0; n < 1000; n++) begin
      if (resp_count[i] >= target) break;
      @(posedge clk);
      #2;
    end
    check("resp_wait", i, 32'(resp_count[i] >= target), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0, a1, a2, a3, base;
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'd0; addr[i] = 32'd0; wstrb[i] = 4'd0;
      wdata[i] = 32'd0; mh[i] = 0; mt[i] = 0; last_resp[i] = -100; resp_count[i] = 0;
    end
    fork
      monitor();
    join_none

    // reset then idle
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_addrok", i, 32'(addrok[i]), 32'd1);
      check("rst_dataok", i, 32'(dataok[i]), 32'd0);
      check("rst_ram_en", i, 32'(ram_en[i]), 32'd0);
    end
    wait_cycles(2);

    // single write then read, no delay
    send(0, 1'b1, 2'd2, 32'h0000_0010, 4'b1111, 32'h1122_3344, a0);
    idle(0);
    wait_cycles(1);
    check("issue_en", 0, 32'(ram_en[0]), 32'd1);
    check("issue_addr", 0, 32'(ram_addr[0]), 32'd4);
    check("issue_wen", 0, 32'(ram_wen[0]), 32'hF);
    wait_cycles(3);
    send(0, 1'b0, 2'd2, 32'h0000_0010, 4'b0000, 32'd0, a0);
    idle(0);
    wait_cycles(2);
    check("rd_dataok", 0, 32'(dataok[0]), 32'd1);
    check("rd_data", 0, rdata[0], 32'h1122_3344);
    wait_cycles(3);

    // byte write into lane 2
    send(0, 1'b1, 2'd0, 32'h0000_0012, 4'b0100, 32'hAAAA_AAAA, a0);
    idle(0);
    wait_cycles(4);
    send(0, 1'b0, 2'd2, 32'h0000_0010, 4'b0000, 32'd0, a0);
    idle(0);
    wait_cycles(2);
    check("byte_dataok", 0, 32'(dataok[0]), 32'd1);
    check("byte_data", 0, rdata[0], 32'h11AA_3344);
    wait_cycles(3);

    // backpressure, RESP_DELAY 4: preload, then 4 back-to-back reads
    for (int k = 0; k < 4; k++) begin
      send(1, 1'b1, 2'd2, 32'h40 + 32'(4 * k), 4'b1111, 32'hB000_0000 + 32'(k), a0);
    end
    idle(1);
    wait_resp(1, 4);
    wait_cycles(3);
    base = resp_count[1];
    send(1, 1'b0, 2'd2, 32'h40, 4'b0000, 32'd0, a0);
    send(1, 1'b0, 2'd2, 32'h44, 4'b0000, 32'd0, a1);
    check("bp_full_addrok", 1, 32'(addrok[1]), 32'd0);
    send(1, 1'b0, 2'd2, 32'h48, 4'b0000, 32'd0, a2);
    send(1, 1'b0, 2'd2, 32'h4C, 4'b0000, 32'd0, a3);
    idle(1);
    check("bp_acc1", 1, 32'(a1 - a0), 32'd1);
    check("bp_acc2", 1, 32'(a2 - a0), 32'd8);
    check("bp_acc3", 1, 32'(a3 - a0), 32'd15);
    wait_resp(1, base + 4);
    check("bp_lat0", 1, 32'(resp_cyc[1][base % 64] - a0), 32'd6);
    for (int k = 1; k < 4; k++)
      check("bp_space", 1, 32'(resp_cyc[1][(base + k) % 64] - resp_cyc[1][(base + k - 1) % 64]), 32'd7);
    wait_cycles(3);

    // wrap-around: 9 writes then 9 reads through a 2-entry FIFO
    base = resp_count[0];
    for (int k = 0; k < 9; k++)
      send(0, 1'b1, 2'd2, 32'(4 * k), 4'b1111, 32'hC0DE_0000 + 32'(k * 17), a0);
    for (int k = 0; k < 9; k++)
      send(0, 1'b0, 2'd2, 32'(4 * k), 4'b0000, 32'd0, a0);
    idle(0);
    wait_resp(0, base + 18);
    wait_cycles(10);
    check("wrap_count", 0, 32'(resp_count[0] - base), 32'd18);

    // reset while in WAIT with two entries queued
    send(1, 1'b0, 2'd2, 32'h40, 4'b0000, 32'd0, a0);
    send(1, 1'b0, 2'd2, 32'h44, 4'b0000, 32'd0, a1);
    idle(1);
    check("mid_full_addrok", 1, 32'(addrok[1]), 32'd0);
    resetn = 1'b0;
    #1;
    check("async_addrok", 1, 32'(addrok[1]), 32'd1);
    check("async_dataok", 1, 32'(dataok[1]), 32'd0);
    check("async_ram_en", 1, 32'(ram_en[1]), 32'd0);
    wait_cycles(2);
    resetn = 1'b1;
    base = resp_count[1];
    wait_cycles(20);
    check("mid_no_resp", 1, 32'(resp_count[1] - base), 32'd0);
    check("mid_addrok", 1, 32'(addrok[1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
